regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter NUM_WR, default 2, number of write ports (issue slots); slot order = program order, lower index older.
REQ-002 SHALL have parameter NUM_RD, default 4, number of read ports.
REQ-003 SHALL have parameter DATA_W, default 32, register width.
REQ-004 SHALL have parameter NUM_REGS, default 32, register count; AW = clog2(NUM_REGS).
REQ-005 SHALL have parameter SP_IDX, default 29, and INIT_SP, default 32'h0000_1c00, which set the stack-pointer index and its init value.
REQ-006 SHALL have one clock and synchronous active-high reset, ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-007 SHALL have ports we input NUM_WR, wa input NUM_WR*AW, wd input NUM_WR*DATA_W (write enables, addresses, data; slot i at bits [i*W +: W]).
REQ-008 SHALL have ports re input NUM_RD, ra input NUM_RD*AW, rd output NUM_RD*DATA_W, rd_busy output NUM_RD (read enables, addresses, data, operand-pending flags).
REQ-009 SHALL have ports rsv_en input NUM_WR, rsv_addr input NUM_WR*AW (issue-time destination reservations).
REQ-010 SHALL have port ready output 1, high when initialisation is complete and the file accepts traffic.

Function
REQ-011 SHALL implement a two-state FSM, INIT and RUN; rst forces INIT with init counter = 1.
REQ-012 In INIT, SHALL write one register per cycle at index cnt: value INIT_SP if cnt == SP_IDX, else 0; cnt increments; after writing NUM_REGS-1, SHALL go to RUN next cycle.
REQ-013 In INIT, SHALL ignore we and rsv_en, drive rd = 0 and rd_busy = 0, ready = 0.
REQ-014 In RUN, ready = 1; INIT lasts exactly NUM_REGS-1 cycles after rst deasserts (31 at default).
REQ-015 Register 0 SHALL read 0 always; writes and reservations to address 0 SHALL be discarded.
REQ-016 Writes SHALL commit on the rising clock edge; multiple write ports hitting the same address same cycle: highest slot index wins.
REQ-017 Read is combinational: re = 0 or ra = 0 -> rd = 0; else if any write port has we = 1 and wa == ra -> wd of the highest such slot (bypass); else stored value.
REQ-018 SHALL keep one busy bit per register; rsv_en[i] with rsv_addr[i] != 0 SHALL set busy on the next edge.
REQ-019 we[i] with wa[i] != 0 SHALL clear busy for wa[i] on the next edge; if set and clear hit the same register same cycle, set wins.
REQ-020 rd_busy[j] = re[j] & (ra[j] != 0) & busy[ra[j]] & ~(same-cycle write to ra[j]); a bypassed operand is never busy.
REQ-021 Out-of-range addresses (>= NUM_REGS, non-power-of-two NUM_REGS) SHALL be treated as address 0.

Reset
REQ-022 On rst: FSM = INIT, cnt = 1, all busy bits = 0, ready = 0, rd = 0, rd_busy = 0; register contents are then rewritten by INIT, not by rst.
REQ-023 rst asserted mid-INIT or mid-RUN SHALL restart INIT from cnt = 1 on the following cycle, and all in-flight writes and reservations that cycle SHALL be dropped.

Verification
REQ-024 rst 1 cycle, then idle -> ready low 31 cycles, high on cycle 32; read r29 = 0x00001c00, r5 = 0.
REQ-025 RUN: we[0] wa=5 wd=0xAAAA and we[1] wa=5 wd=0xBBBB same cycle -> r5 = 0xBBBB after edge; same-cycle read of r5 returns 0xBBBB via bypass.
REQ-026 rsv_en[0] addr=7; next cycle re[0] ra=7 -> rd_busy[0]=1; then we[1] wa=7 wd=0x1234 -> rd_busy[0]=0, rd[0]=0x1234 same cycle, busy cleared after edge.
REQ-027 Same cycle rsv_en[1] addr=9 and we[0] wa=9 -> after edge r9 = written data and busy[9] = 1.
REQ-028 Write 0xFFFF to r0 plus rsv_en addr=0 -> rd of r0 = 0, rd_busy = 0.
REQ-029 rst asserted at INIT cycle 10 -> ready stays low further 31 cycles; we during INIT has no effect on any register.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file with write bypass, per-register busy scoreboard
// and a self-initialising INIT phase that loads the stack pointer after reset.
module regfile_mp #(
   parameter int NUM_WR   = 2,
   parameter int NUM_RD   = 4,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int SP_IDX   = 29,
   parameter logic [DATA_W-1:0] INIT_SP = DATA_W'(32'h0000_1c00),
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*AW-1:0]     wa,
   input  logic [NUM_WR*DATA_W-1:0] wd,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*AW-1:0]     ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        rsv_en,
   input  logic [NUM_WR*AW-1:0]     rsv_addr,
   output logic                     ready
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [AW:0]   NREGS_V  = (AW+1)'(NUM_REGS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS-1);
   localparam logic [AW-1:0] SP_A     = AW'(SP_IDX);
   localparam logic [AW-1:0] CNT_ONE  = AW'(1'b1);

   state_t                state_r;
   logic [AW-1:0]         cnt_r;
   logic                  ready_r;
   logic [NUM_REGS-1:0]   busy_r;
   logic [DATA_W-1:0]     regs_r [NUM_REGS];

   logic [AW-1:0]         wa_s   [NUM_WR];
   logic [DATA_W-1:0]     wd_s   [NUM_WR];
   logic [AW-1:0]         rsv_s  [NUM_WR];
   logic [AW-1:0]         ra_s   [NUM_RD];
   logic [DATA_W-1:0]     rval_s [NUM_RD];
   logic                  rbsy_s [NUM_RD];

   // Address 0 and anything beyond the file behave as the hard-wired zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != {AW{1'b0}}) && ({1'b0, a} < NREGS_V);
   endfunction

   // Unpack the flat port vectors into per-slot arrays.
   always_comb begin
      for (int i = 0; i < NUM_WR; i++) begin
         wa_s[i]  = wa[i*AW +: AW];
         wd_s[i]  = wd[i*DATA_W +: DATA_W];
         rsv_s[i] = rsv_addr[i*AW +: AW];
      end
      for (int j = 0; j < NUM_RD; j++) begin
         ra_s[j] = ra[j*AW +: AW];
      end
   end

   // Sequencer, ready flag and busy scoreboard.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_INIT;
         cnt_r   <= CNT_ONE;
         ready_r <= 1'b0;
         busy_r  <= {NUM_REGS{1'b0}};
      end else begin
         case (state_r)
            ST_INIT: begin
               cnt_r <= cnt_r + CNT_ONE;
               if (cnt_r == LAST_IDX) begin
                  state_r <= ST_RUN;
                  ready_r <= 1'b1;
               end
            end
            ST_RUN: begin
               // Clears first so that a same-cycle reservation wins.
               for (int i = 0; i < NUM_WR; i++) begin
                  if (we[i] && addr_ok(wa_s[i])) busy_r[wa_s[i]] <= 1'b0;
               end
               for (int i = 0; i < NUM_WR; i++) begin
                  if (rsv_en[i] && addr_ok(rsv_s[i])) busy_r[rsv_s[i]] <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_INIT;
               cnt_r   <= CNT_ONE;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   // Register storage: INIT sweep, then program-ordered commits (last slot wins).
   always_ff @(posedge clk) begin
      if (!rst && state_r == ST_INIT) begin
         regs_r[cnt_r] <= (cnt_r == SP_A) ? INIT_SP : {DATA_W{1'b0}};
      end else if (!rst && state_r == ST_RUN) begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] && addr_ok(wa_s[i])) regs_r[wa_s[i]] <= wd_s[i];
         end
      end
   end

   // Combinational read with bypass from the youngest matching write slot.
   always_comb begin
      for (int j = 0; j < NUM_RD; j++) begin
         rval_s[j] = {DATA_W{1'b0}};
         rbsy_s[j] = 1'b0;
         if (!rst && state_r == ST_RUN && re[j] && addr_ok(ra_s[j])) begin
            rval_s[j] = regs_r[ra_s[j]];
            rbsy_s[j] = busy_r[ra_s[j]];
            for (int i = 0; i < NUM_WR; i++) begin
               if (we[i] && wa_s[i] == ra_s[j]) begin
                  rval_s[j] = wd_s[i];
                  rbsy_s[j] = 1'b0;
               end else begin
                  rval_s[j] = rval_s[j];
               end
            end
         end else begin
            rval_s[j] = {DATA_W{1'b0}};
            rbsy_s[j] = 1'b0;
         end
      end
   end

   // Repack read results onto the flat output ports.
   always_comb begin
      for (int j = 0; j < NUM_RD; j++) begin
         rd[j*DATA_W +: DATA_W] = rval_s[j];
         rd_busy[j]             = rbsy_s[j];
      end
   end

   assign ready = ready_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, reset/INIT sequences and
// randomized traffic against a behavioural reference model.
module tb_regfile_mp;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   we;
   logic [9:0]   wa;
   logic [63:0]  wd;
   logic [3:0]   re;
   logic [19:0]  ra;
   logic [127:0] rd;
   logic [3:0]   rd_busy;
   logic [1:0]   rsv_en;
   logic [9:0]   rsv_addr;
   logic         ready;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_mem  [32];
   logic        m_busy [32];
   bit          m_run  = 1'b0;
   int          m_left = 0;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [1:0]  rsv_en;
      logic [4:0]  rs0;
      logic [4:0]  rs1;
      logic        re0;
      logic [4:0]  ra0;
      logic [31:0] exp_rd;
      logic        exp_busy;
   } vec_t;

   vec_t tbl [13];

   regfile_mp dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .re       (re),
      .ra       (ra),
      .rd       (rd),
      .rd_busy  (rd_busy),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1, input logic [1:0] rv,
                               input logic [4:0] r0, input logic [4:0] r1, input logic e0,
                               input logic [4:0] q0, input logic [31:0] xr, input logic xb);
      vec_t v;
      v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1; v.rsv_en = rv;
      v.rs0 = r0; v.rs1 = r1; v.re0 = e0; v.ra0 = q0; v.exp_rd = xr; v.exp_busy = xb;
      return v;
   endfunction

   function automatic logic [4:0] rnd_addr();
      return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      we = 2'b00; wa = 10'd0; wd = 64'd0; re = 4'b0000; ra = 20'd0;
      rsv_en = 2'b00; rsv_addr = 10'd0;
   endtask

   // compare every output against the model, mid-cycle
   task automatic sample();
      @(negedge clk);
      chk("ready", {31'd0, ready}, {31'd0, m_run});
      for (int j = 0; j < 4; j++) begin
         logic [4:0]  a;
         logic [31:0] e;
         logic        eb;
         a = ra[j*5 +: 5];
         e = 32'd0;
         eb = 1'b0;
         if (m_run && !rst && re[j] && a != 5'd0) begin
            e = m_mem[a];
            eb = m_busy[a];
            for (int i = 0; i < 2; i++) begin
               if (we[i] && wa[i*5 +: 5] == a) begin
                  e = wd[i*32 +: 32];
                  eb = 1'b0;
               end
            end
         end
         chk($sformatf("rd%0d", j), rd[j*32 +: 32], e);
         chk($sformatf("rd_busy%0d", j), {31'd0, rd_busy[j]}, {31'd0, eb});
      end
   endtask

   // clock edge: update the model from the inputs held this cycle
   task automatic advance();
      @(posedge clk);
      if (rst) begin
         m_run = 1'b0;
         m_left = 31;
         for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
      end else if (!m_run) begin
         m_left--;
         if (m_left == 0) begin
            m_run = 1'b1;
            for (int k = 0; k < 32; k++) m_mem[k] = (k == 29) ? 32'h0000_1c00 : 32'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (we[i] && wa[i*5 +: 5] != 5'd0) begin
               m_mem[wa[i*5 +: 5]] = wd[i*32 +: 32];
               m_busy[wa[i*5 +: 5]] = 1'b0;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (rsv_en[i] && rsv_addr[i*5 +: 5] != 5'd0) m_busy[rsv_addr[i*5 +: 5]] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!ready && n < 100) begin
         sample();
         advance();
         n++;
      end
      chk(name, n, 32'd31);
   endtask

   initial begin
      tbl[0]  = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b1, 5'd29, 32'h0000_1c00, 1'b0);
      tbl[1]  = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b1, 5'd5,  32'h0,         1'b0);
      tbl[2]  = mk(2'b11, 5'd5, 32'hAAAA, 5'd5, 32'hBBBB, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5,  32'hBBBB,      1'b0);
      tbl[3]  = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b1, 5'd5,  32'hBBBB,      1'b0);
      tbl[4]  = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b01, 5'd7, 5'd0, 1'b1, 5'd7,  32'h0,         1'b0);
      tbl[5]  = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b1, 5'd7,  32'h0,         1'b1);
      tbl[6]  = mk(2'b10, 5'd0, 32'h0,    5'd7, 32'h1234, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7,  32'h1234,      1'b0);
      tbl[7]  = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b1, 5'd7,  32'h1234,      1'b0);
      tbl[8]  = mk(2'b01, 5'd9, 32'h5555, 5'd0, 32'h0,    2'b10, 5'd0, 5'd9, 1'b1, 5'd9,  32'h5555,      1'b0);
      tbl[9]  = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b1, 5'd9,  32'h5555,      1'b1);
      tbl[10] = mk(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0,    2'b01, 5'd0, 5'd0, 1'b1, 5'd0,  32'h0,         1'b0);
      tbl[11] = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b1, 5'd0,  32'h0,         1'b0);
      tbl[12] = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 1'b0, 5'd5,  32'h0,         1'b0);

      idle();
      rst = 1'b1;
      advance();
      rst = 1'b0;
      wait_ready("init_len");

      // directed vectors in RUN
      for (int v = 0; v < 13; v++) begin
         we = tbl[v].we;
         wa = {tbl[v].wa1, tbl[v].wa0};
         wd = {tbl[v].wd1, tbl[v].wd0};
         rsv_en = tbl[v].rsv_en;
         rsv_addr = {tbl[v].rs1, tbl[v].rs0};
         re = {3'b000, tbl[v].re0};
         ra = {15'd0, tbl[v].ra0};
         sample();
         chk($sformatf("vec%0d_rd", v), rd[31:0], tbl[v].exp_rd);
         chk($sformatf("vec%0d_busy", v), {31'd0, rd_busy[0]}, {31'd0, tbl[v].exp_busy});
         advance();
      end
      idle();

      // reset restarted at INIT cycle 10, with writes attempted during INIT
      rst = 1'b1;
      advance();
      rst = 1'b0;
      we = 2'b11;
      wa = {5'd29, 5'd3};
      wd = {32'hDEAD_0029, 32'hDEAD_0003};
      rsv_en = 2'b01;
      rsv_addr = {5'd0, 5'd3};
      for (int c = 0; c < 10; c++) begin
         sample();
         advance();
      end
      rst = 1'b1;
      sample();
      advance();
      rst = 1'b0;
      wait_ready("reinit_len");
      idle();
      re = 4'b0011;
      ra = {10'd0, 5'd29, 5'd3};
      sample();
      chk("init_r3", rd[31:0], 32'h0);
      chk("init_r29", rd[63:32], 32'h0000_1c00);
      chk("init_r3_busy", {31'd0, rd_busy[0]}, 32'd0);
      advance();

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 399) == 0);
         we = 2'($urandom);
         re = 4'($urandom);
         rsv_en = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         for (int i = 0; i < 2; i++) begin
            wa[i*5 +: 5] = rnd_addr();
            wd[i*32 +: 32] = $urandom;
            rsv_addr[i*5 +: 5] = rnd_addr();
         end
         for (int j = 0; j < 4; j++) ra[j*5 +: 5] = rnd_addr();
         sample();
         advance();
      end
      rst = 1'b0;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
